mux_grant_scheduler: RTL and testbench
======================================

Name: mux_grant_scheduler

Overview:
- Sequences the select of the project's N:1 byte output mux. Multiple requesters contend for the mux; the block grants one at a time (round-robin or fixed priority) and drives the mux select.
- Enforces a programmable minimum dwell per grant and a break-before-make gap on every switch.
- Sits between the requester logic and the mux inside the top-level user project. Driven from the top-level clk, rst_n and ena.

Parameters:
- N_REQ, 4, number of requesters / mux inputs (power of two, 2..8)
- SEL_W, 2, select width = log2(N_REQ)
- DWELL_W, 4, width of dwell count input
- GAP_CYCLES, 1, idle cycles (grant=0) inserted between grants (>=1)

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-low
- ena  in  1  design enable; low freezes all state
- req  in  N_REQ  per-requester request level
- lock  in  1  holder may keep grant past dwell expiry
- prio_mode  in  1  0 = round-robin, 1 = fixed priority (index 0 highest)
- dwell  in  DWELL_W  minimum extra hold cycles, sampled at grant entry
- grant  out  N_REQ  one-hot grant, registered
- sel  out  SEL_W  mux select, index of current/last holder, registered
- busy  out  1  high in GRANT and GAP states
- switch_pulse  out  1  one-cycle pulse on the first cycle of each new grant

Behaviour:
- Interface: one clock; reset is synchronous and active-low (clk, rst_n).
- Reset (rst_n=0 at a clk edge), taking priority over ena:
  - state=IDLE; grant=0, sel=0, busy=0, switch_pulse=0.
  - RR pointer=0, dwell counter cnt=0, gap counter=0.
- ena=0: all registers hold, except that switch_pulse clears to 0.
- States: IDLE, GRANT, GAP. All outputs are registered.
- IDLE:
  - If req!=0 at edge t, the edge moves to GRANT at t+1 with grant=onehot(w), sel=w, busy=1, switch_pulse=1, cnt=dwell.
  - If req=0, stay in IDLE.
- Arbitration winner w:
  - prio_mode=1: lowest set index of req.
  - prio_mode=0: first set index scanning from (ptr+1) mod N_REQ upward with wrap. ptr<=w on every grant.
- GRANT:
  - cnt decrements each cycle and saturates at 0.
  - Holder req drops → release. This applies immediately, regardless of dwell or lock.
  - cnt==0, lock=0, and a contender exists → release.
    - Contender, RR mode: any other req set.
    - Contender, fixed mode: a higher-priority req set.
  - Otherwise hold, with no switch_pulse.
  - On release: next state GAP, grant=0, sel held, busy=1, gap counter=GAP_CYCLES-1.
- GAP:
  - Counts down. On the last gap cycle, arbitrate on the current req.
  - If req!=0 → GRANT, with the same entry actions as from IDLE.
  - Otherwise → IDLE with busy=0.
  - The previous holder may win again if it is the only requester.
- Minimum hold under contention is dwell+1 cycles.
- With dwell=0 and GAP_CYCLES=1, a switch period is 1 grant cycle + 1 gap cycle.
- Simultaneous holder-drop and dwell expiry: a single release.
- lock rising mid-dwell extends the grant. lock falling with cnt==0 and a contender pending releases at the next edge.
- Reset mid-GRANT: grant=0 on that edge, with no GAP state.
- grant and sel are never changed in the same cycle as a non-zero-to-different-non-zero transition (break-before-make guaranteed).

Decomposition:
- Package mux_sched_pkg holds:
  - state enum {IDLE, GRANT, GAP}
  - default N_REQ, SEL_W, DWELL_W, GAP_CYCLES constants
  - onehot/index conversion function
- Sub-module rr_pick: combinational.
  - Inputs: req, base pointer, mode, optional mask.
  - Outputs: found, winner index.
- Top module holds the FSM, counters and registered outputs.

Test Plan:
- Reset: rst_n=0 for 2 cycles with req=4'b1111 → grant=0, sel=0, busy=0, switch_pulse=0. Release reset → grant=0001 one cycle later.
- Single requester: req=0100 from t0, dwell=3 → at t1 grant=0100, sel=2, switch_pulse=1. Holds for 30 cycles with switch_pulse=0 after t1.
- Round-robin contention: req=1111 held, dwell=2, prio_mode=0.
  - Grants in order 0001,0010,0100,1000,0001.
  - Each grant held 3 cycles, separated by 1 cycle of grant=0.
- Fixed priority: prio_mode=1, req=1010, dwell=0 → grant=0010 indefinitely. Raising req[0] → 0010 dropped, 1 gap cycle, then 0001.
- Lock and ena:
  - lock=1, req=0011, dwell=0 → grant=0001 held 20 cycles. Dropping req[0] → gap, then 0010.
  - ena=0 for 5 cycles mid-grant → all outputs frozen.
- Reset mid-operation: assert rst_n=0 while in GAP with req=1111 → next edge IDLE, ptr=0. After release, first grant=0010 in RR mode.

Source files
------------

// File: rtl/mux_sched_pkg.sv
// Shared types and constants for the output-mux grant scheduler.
// Holds the FSM state encoding, default sizing and the index-to-onehot helper.
package mux_sched_pkg;

    localparam int N_REQ_DEF      = 4;
    localparam int SEL_W_DEF      = 2;
    localparam int DWELL_W_DEF    = 4;
    localparam int GAP_CYCLES_DEF = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_GAP
    } state_e;

    // Sized for the largest supported requester count (8); callers narrow it.
    function automatic logic [7:0] idx_to_onehot(input logic [2:0] idx);
        idx_to_onehot = 8'd1 << idx;
    endfunction

endpackage

// File: rtl/mux_grant_scheduler_rr_pick.sv
// Combinational arbiter: picks the lowest set index (fixed mode) or the first
// set index after base with wrap (round-robin). Ports: req, base, fixed, mask -> found, winner.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int SEL_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] base,
    input  logic             fixed,
    input  logic [N_REQ-1:0] mask,
    output logic             found,
    output logic [SEL_W-1:0] winner
);

    logic [N_REQ-1:0] cand;
    logic [SEL_W-1:0] j;

    assign cand = req & mask;

    // N_REQ is a power of two, so SEL_W-bit addition wraps the scan.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        j      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            j = fixed ? SEL_W'(i) : SEL_W'(base + SEL_W'(i) + SEL_W'(1));
            if (!found && cand[j]) begin
                found  = 1'b1;
                winner = j;
            end
        end
    end

endmodule

// File: rtl/mux_grant_scheduler.sv
// Grant scheduler for the N:1 byte output mux: one holder at a time, minimum
// dwell, break-before-make gap. Ports: clk, rst_n, ena, req, lock, prio_mode,
// dwell in; grant, sel, busy, switch_pulse out (all registered).
module mux_grant_scheduler
    import mux_sched_pkg::*;
#(
    parameter int N_REQ      = N_REQ_DEF,
    parameter int SEL_W      = SEL_W_DEF,
    parameter int DWELL_W    = DWELL_W_DEF,
    parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic [N_REQ-1:0]   req,
    input  logic               lock,
    input  logic               prio_mode,
    input  logic [DWELL_W-1:0] dwell,
    output logic [N_REQ-1:0]   grant,
    output logic [SEL_W-1:0]   sel,
    output logic               busy,
    output logic               switch_pulse
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    state_e             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               busy_q, busy_d;
    logic               pulse_q, pulse_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [GAP_W-1:0]   gap_q, gap_d;

    logic               pick_found;
    logic [SEL_W-1:0]   pick_idx;
    logic               contender;
    logic               enter;

    rr_pick #(
        .N_REQ (N_REQ),
        .SEL_W (SEL_W)
    ) u_pick (
        .req    (req),
        .base   (ptr_q),
        .fixed  (prio_mode),
        .mask   ({N_REQ{1'b1}}),
        .found  (pick_found),
        .winner (pick_idx)
    );

    // grant_q - 1 on a one-hot gives every index of higher priority.
    always_comb begin
        if (prio_mode) begin
            contender = |(req & (grant_q - N_REQ'(1)));
        end else begin
            contender = |(req & ~grant_q);
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        busy_d  = busy_q;
        pulse_d = 1'b0;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        enter   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                enter = pick_found;
            end
            ST_GRANT: begin
                cnt_d = (cnt_q == '0) ? '0 : cnt_q - DWELL_W'(1);
                if (!req[sel_q] ||
                    (cnt_q == '0 && !lock && contender)) begin
                    state_d = ST_GAP;
                    grant_d = '0;
                    busy_d  = 1'b1;
                    gap_d   = GAP_W'(GAP_CYCLES - 1);
                end
            end
            ST_GAP: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - GAP_W'(1);
                end else if (pick_found) begin
                    enter = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (enter) begin
            state_d = ST_GRANT;
            grant_d = N_REQ'(idx_to_onehot(3'(pick_idx)));
            sel_d   = pick_idx;
            busy_d  = 1'b1;
            pulse_d = 1'b1;
            cnt_d   = dwell;
            ptr_d   = pick_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            busy_q  <= 1'b0;
            pulse_q <= 1'b0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
        end else if (ena) begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            pulse_q <= pulse_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
        end else begin
            pulse_q <= 1'b0;
        end
    end

    assign grant        = grant_q;
    assign sel          = sel_q;
    assign busy         = busy_q;
    assign switch_pulse = pulse_q;

endmodule

// File: tb/tb_mux_grant_scheduler.sv
// Self-checking bench for mux_grant_scheduler.
// Per-cycle vector table, compared after each edge.
module tb_mux_grant_scheduler;

  typedef struct {
    logic       rst_n;
    logic       ena;
    logic [3:0] req;
    logic       lock;
    logic       prio;
    logic [3:0] dwell;
    logic [3:0] e_grant;
    logic [1:0] e_sel;
    logic       e_busy;
    logic       e_pulse;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [3:0] req = '0;
  logic       lock = 1'b0;
  logic       prio_mode = 1'b0;
  logic [3:0] dwell = '0;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       busy;
  logic       switch_pulse;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   done = 1'b0;

  always #5 clk = ~clk;

  mux_grant_scheduler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .req          (req),
    .lock         (lock),
    .prio_mode    (prio_mode),
    .dwell        (dwell),
    .grant        (grant),
    .sel          (sel),
    .busy         (busy),
    .switch_pulse (switch_pulse)
  );

  function automatic void add(
    input logic r, input logic e,
    input logic [3:0] q,
    input logic l, input logic p,
    input logic [3:0] d,
    input logic [3:0] g,
    input logic [1:0] s,
    input logic b, input logic sp);
    vec_t v;
    v.rst_n = r; v.ena = e;
    v.req = q; v.lock = l;
    v.prio = p; v.dwell = d;
    v.e_grant = g; v.e_sel = s;
    v.e_busy = b; v.e_pulse = sp;
    vecs.push_back(v);
  endfunction

  initial begin
    #200000;
    if (!done) begin
      errors++;
      $display("FAIL timeout: vectors not finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  initial begin
    vec_t v;
    vec_t e;
    logic [1:0] w;
    logic [3:0] oh;

    @(negedge clk);
    rst_n = 1'b0;
    req = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (grant !== 4'b0000 || sel !== 2'd0 ||
        busy !== 1'b0 || switch_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset g=%b s=%0d b=%b p=%b",
               grant, sel, busy, switch_pulse);
    end

    add(0, 1, 4'b1111, 0, 1, 0, 4'b0000, 0, 0, 0);
    add(0, 1, 4'b1111, 0, 1, 0, 4'b0000, 0, 0, 0);
    add(1, 1, 4'b1111, 0, 1, 0, 4'b0001, 0, 1, 1);
    add(1, 1, 4'b1111, 0, 1, 0, 4'b0001, 0, 1, 0);
    add(0, 1, 4'b1111, 0, 1, 0, 4'b0000, 0, 0, 0);

    add(1, 1, 4'b0100, 0, 0, 3, 4'b0100, 2, 1, 1);
    for (int i = 0; i < 30; i++)
      add(1, 1, 4'b0100, 0, 0, 3, 4'b0100, 2, 1, 0);
    add(1, 1, 4'b0000, 0, 0, 3, 4'b0000, 2, 1, 0);
    add(1, 1, 4'b0000, 0, 0, 3, 4'b0000, 2, 0, 0);

    for (int k = 0; k < 5; k++) begin
      w = 2'(3 + k);
      oh = 4'b0001 << w;
      add(1, 1, 4'b1111, 0, 0, 2, oh, w, 1, 1);
      add(1, 1, 4'b1111, 0, 0, 2, oh, w, 1, 0);
      add(1, 1, 4'b1111, 0, 0, 2, oh, w, 1, 0);
      add(1, 1, 4'b1111, 0, 0, 2, 4'b0000, w, 1, 0);
    end
    add(1, 1, 4'b0000, 0, 0, 2, 4'b0000, 3, 0, 0);

    add(1, 1, 4'b0011, 1, 0, 0, 4'b0001, 0, 1, 1);
    for (int i = 0; i < 5; i++)
      add(1, 0, 4'b0000, 0, 0, 0, 4'b0001, 0, 1, 0);
    for (int i = 0; i < 20; i++)
      add(1, 1, 4'b0011, 1, 0, 0, 4'b0001, 0, 1, 0);
    add(1, 1, 4'b0010, 1, 0, 0, 4'b0000, 0, 1, 0);
    add(1, 1, 4'b0010, 1, 0, 0, 4'b0010, 1, 1, 1);
    for (int i = 0; i < 3; i++)
      add(1, 1, 4'b0011, 1, 0, 0, 4'b0010, 1, 1, 0);
    add(1, 1, 4'b0011, 0, 0, 0, 4'b0000, 1, 1, 0);
    add(1, 1, 4'b0011, 0, 0, 0, 4'b0001, 0, 1, 1);
    add(1, 1, 4'b0000, 0, 0, 0, 4'b0000, 0, 1, 0);
    add(1, 1, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 0);

    add(1, 1, 4'b1010, 0, 1, 0, 4'b0010, 1, 1, 1);
    for (int i = 0; i < 10; i++)
      add(1, 1, 4'b1010, 0, 1, 0, 4'b0010, 1, 1, 0);
    add(1, 1, 4'b1011, 0, 1, 0, 4'b0000, 1, 1, 0);
    add(1, 1, 4'b1011, 0, 1, 0, 4'b0001, 0, 1, 1);
    add(1, 1, 4'b1011, 0, 1, 0, 4'b0001, 0, 1, 0);
    add(1, 1, 4'b0000, 0, 1, 0, 4'b0000, 0, 1, 0);
    add(1, 1, 4'b0000, 0, 1, 0, 4'b0000, 0, 0, 0);

    add(1, 1, 4'b1111, 0, 0, 0, 4'b0010, 1, 1, 1);
    add(1, 1, 4'b1111, 0, 0, 0, 4'b0000, 1, 1, 0);
    add(0, 1, 4'b1111, 0, 0, 0, 4'b0000, 0, 0, 0);
    add(1, 1, 4'b1111, 0, 0, 0, 4'b0010, 1, 1, 1);
    add(0, 1, 4'b1111, 0, 0, 0, 4'b0000, 0, 0, 0);
    add(0, 1, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 0);

    for (int n = 0; n < vecs.size(); n++) begin
      @(negedge clk);
      v = vecs[n];
      rst_n = v.rst_n;
      ena = v.ena;
      req = v.req;
      lock = v.lock;
      prio_mode = v.prio;
      dwell = v.dwell;
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (grant !== e.e_grant ||
          sel !== e.e_sel ||
          busy !== e.e_busy ||
          switch_pulse !== e.e_pulse) begin
        errors++;
        $display("FAIL vec%0d got g=%b s=%0d b=%b p=%b",
                 n, grant, sel, busy, switch_pulse);
        $display("  want g=%b s=%0d b=%b p=%b",
                 e.e_grant, e.e_sel,
                 e.e_busy, e.e_pulse);
      end
    end

    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    if (errors == 0)
      $display("PASS");
    else
      $display("FAIL");
    $finish;
  end

endmodule
